// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the NES SDRAM port arbiter.
package sdram_arb_pkg;
    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {REQ_NONE, REQ_PPU, REQ_CPU, REQ_DL} req_sel_t;
    typedef enum logic [1:0] {ST_WAIT, ST_BUSY, ST_ACK} arb_state_t;
endpackage

// File: rtl/sdram_slot_timer.sv
// Detects the rising edge of clkref (slot start) and counts clk cycles into the current slot.
module sdram_slot_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clkref,
    output logic             slot_start,
    output logic [CNT_W-1:0] slot_cnt
);
    logic             clkref_d;
    logic [CNT_W-1:0] cnt_q;

    assign slot_start = !clkref_d && clkref;
    // The slot-start cycle itself reads as 0, so slot_cnt equals cycles elapsed since slot start.
    assign slot_cnt   = slot_start ? '0 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clkref_d <= 1'b0;
            cnt_q    <= '0;
        end else begin
            clkref_d <= clkref;
            if (slot_start)
                cnt_q <= CNT_W'(1);
            else if (cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// Grants the single SDRAM port to PPU, CPU or downloader once per clkref slot, with
// downloader anti-starvation and forced idle slots for auto-refresh.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DATA_CYCLE    = 9,
    parameter int unsigned DL_MAX_WAIT   = 4,
    parameter int unsigned REFRESH_SLOTS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clkref,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_ack,
    output logic [DATA_W-1:0] ppu_dout,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [DATA_W-1:0] dl_din,
    output logic              dl_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_oeA,
    output logic              mem_oeB,
    input  logic [DATA_W-1:0] mem_doutA,
    input  logic [DATA_W-1:0] mem_doutB
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WAIT_W = $clog2(DL_MAX_WAIT + 1);
    localparam int unsigned BUSY_W = $clog2(REFRESH_SLOTS + 1);

    logic              slot_start;
    logic [CNT_W-1:0]  slot_cnt;
    arb_state_t        state, state_next;
    req_sel_t          winner, sel;
    logic              data_done;
    logic [WAIT_W-1:0] dl_wait;
    logic [BUSY_W-1:0] busy_cnt;

    sdram_slot_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clkref     (clkref),
        .slot_start (slot_start),
        .slot_cnt   (slot_cnt)
    );

    always_comb begin
        winner     = REQ_NONE;
        state_next = state;
        if (busy_cnt == BUSY_W'(REFRESH_SLOTS))
            winner = REQ_NONE;
        else if (dl_req && dl_wait == WAIT_W'(DL_MAX_WAIT))
            winner = REQ_DL;
        else if (ppu_req)
            winner = REQ_PPU;
        else if (cpu_req)
            winner = REQ_CPU;
        else if (dl_req)
            winner = REQ_DL;

        // A slot start always wins, so an over-fast clkref drops the in-flight grant unacked.
        if (slot_start) begin
            state_next = (winner != REQ_NONE) ? ST_BUSY : ST_WAIT;
        end else begin
            case (state)
                ST_BUSY: if (slot_cnt == CNT_W'(DATA_CYCLE)) state_next = ST_ACK;
                ST_ACK:  state_next = ST_WAIT;
                default: ;
            endcase
        end
    end

    assign data_done = (state == ST_BUSY) && !slot_start && (slot_cnt == CNT_W'(DATA_CYCLE));

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_WAIT;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel      <= REQ_NONE;
            mem_addr <= '0;
            mem_we   <= 1'b0;
            mem_din  <= '0;
            mem_oeA  <= 1'b0;
            mem_oeB  <= 1'b0;
            ppu_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            dl_ack   <= 1'b0;
            ppu_dout <= '0;
            cpu_dout <= '0;
            dl_wait  <= '0;
            busy_cnt <= '0;
        end else begin
            ppu_ack <= 1'b0;
            cpu_ack <= 1'b0;
            dl_ack  <= 1'b0;

            if (slot_start) begin
                sel      <= winner;
                mem_addr <= '0;
                mem_we   <= 1'b0;
                mem_din  <= '0;
                mem_oeA  <= 1'b0;
                mem_oeB  <= 1'b0;
                case (winner)
                    REQ_PPU: begin
                        mem_addr <= ppu_addr;
                        mem_oeB  <= 1'b1;
                    end
                    REQ_CPU: begin
                        mem_addr <= cpu_addr;
                        mem_we   <= cpu_we;
                        mem_oeA  <= !cpu_we;
                        mem_din  <= cpu_we ? cpu_din : '0;
                    end
                    REQ_DL: begin
                        mem_addr <= dl_addr;
                        mem_we   <= 1'b1;
                        mem_din  <= dl_din;
                    end
                    default: ;
                endcase

                busy_cnt <= (winner == REQ_NONE) ? '0 : busy_cnt + 1'b1;

                if (!dl_req || winner == REQ_DL)
                    dl_wait <= '0;
                else if (dl_wait != WAIT_W'(DL_MAX_WAIT))
                    dl_wait <= dl_wait + 1'b1;
            end else if (state == ST_ACK) begin
                sel      <= REQ_NONE;
                mem_addr <= '0;
                mem_we   <= 1'b0;
                mem_din  <= '0;
                mem_oeA  <= 1'b0;
                mem_oeB  <= 1'b0;
            end

            if (data_done) begin
                case (sel)
                    REQ_PPU: begin
                        ppu_ack  <= 1'b1;
                        ppu_dout <= mem_doutB;
                    end
                    REQ_CPU: begin
                        cpu_ack <= 1'b1;
                        if (!mem_we)
                            cpu_dout <= mem_doutA;
                    end
                    REQ_DL:  dl_ack <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: slot-phase driven clkref, ack scoreboard, refresh/starvation model.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    logic              clk = 1'b0;
    logic              reset, clkref;
    logic              ppu_req, cpu_req, cpu_we, dl_req;
    logic [ADDR_W-1:0] ppu_addr, cpu_addr, dl_addr, mem_addr;
    logic [DATA_W-1:0] cpu_din, dl_din, mem_din, mem_doutA, mem_doutB, ppu_dout, cpu_dout;
    logic              ppu_ack, cpu_ack, dl_ack, mem_we, mem_oeA, mem_oeB;

    typedef struct {
        req_sel_t          src;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ph     = 6;

    sdram_arbiter #(.DATA_CYCLE(9), .DL_MAX_WAIT(4), .REFRESH_SLOTS(64)) dut (
        .clk(clk), .reset(reset), .clkref(clkref),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_dout(ppu_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
        .mem_oeA(mem_oeA), .mem_oeB(mem_oeB), .mem_doutA(mem_doutA), .mem_doutB(mem_doutB)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clk cycle: advance the slot phase (slot start at ph==0), then score any ack.
    task automatic tick();
        req_sel_t s;
        exp_t     e;
        @(posedge clk);
        #1;
        ph     = (ph == 11) ? 0 : ph + 1;
        clkref = (ph < 6);
        if (ppu_ack || cpu_ack || dl_ack) begin
            s = ppu_ack ? REQ_PPU : (cpu_ack ? REQ_CPU : REQ_DL);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(s), 32'(REQ_NONE));
            end else begin
                e = sb.pop_front();
                chk("ack_src", 32'(s), 32'(e.src));
                if (s == REQ_PPU)      chk("ppu_dout", 32'(ppu_dout), 32'(e.data));
                else if (s == REQ_CPU) chk("cpu_dout", 32'(cpu_dout), 32'(e.data));
            end
        end
    endtask

    task automatic wait_ph(input int p);
        for (int i = 0; i < 12 && ph != p; i++) tick();
    endtask

    initial begin
        req_sel_t win;
        int m_busy, m_dlw, idle_cnt, idle_at;

        reset = 1'b1; clkref = 1'b0;
        ppu_req = 0; cpu_req = 0; cpu_we = 0; dl_req = 0;
        ppu_addr = '0; cpu_addr = '0; dl_addr = '0; cpu_din = '0; dl_din = '0;
        mem_doutA = '0; mem_doutB = '0;
        repeat (4) tick();
        reset = 1'b0;
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_ctl", 32'({mem_we, mem_oeA, mem_oeB, ppu_ack, cpu_ack, dl_ack}), 0);
        chk("rst_dout", 32'({ppu_dout, cpu_dout, mem_din}), 0);
        wait_ph(11);

        // CPU read: grant held for the slot, ack exactly 10 cycles after slot start
        cpu_req = 1; cpu_we = 0; cpu_addr = 25'h0001234; mem_doutA = 8'h5A;
        sb.push_back(exp_t'{REQ_CPU, 8'h5A});
        tick();
        chk("rd_oeA_at_start", 32'(mem_oeA), 0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("rd_oeA", 32'(mem_oeA), 1);
            chk("rd_ack_early", 32'(cpu_ack), 0);
        end
        chk("rd_addr", 32'(mem_addr), 32'h0001234);
        tick();
        chk("rd_ack_latency", 32'(cpu_ack), 1);
        chk("rd_oeA_in_ack", 32'(mem_oeA), 1);
        cpu_req = 0;
        tick();
        chk("rd_wait_idle", 32'({mem_oeA, mem_addr}), 0);

        // CPU write: cpu_dout must keep the previous read data
        cpu_req = 1; cpu_we = 1; cpu_addr = 25'h1000000; cpu_din = 8'hA5; mem_doutA = 8'hEE;
        sb.push_back(exp_t'{REQ_CPU, 8'h5A});
        wait_ph(1);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_din", 32'(mem_din), 32'hA5);
        chk("wr_addr", 32'(mem_addr), 32'h1000000);
        chk("wr_oeA", 32'(mem_oeA), 0);
        wait_ph(10);
        chk("wr_ack", 32'(cpu_ack), 1);
        cpu_req = 0; cpu_we = 0;
        wait_ph(11);
        chk("wr_wait_we", 32'(mem_we), 0);

        // PPU and CPU together: PPU first, CPU the following slot
        ppu_req = 1; ppu_addr = 25'h00ABCDE; mem_doutB = 8'h3C;
        cpu_req = 1; cpu_addr = 25'h0000777; mem_doutA = 8'h77;
        sb.push_back(exp_t'{REQ_PPU, 8'h3C});
        sb.push_back(exp_t'{REQ_CPU, 8'h77});
        wait_ph(1);
        chk("pc_oe_ppu", 32'({mem_oeB, mem_oeA}), 32'b10);
        chk("pc_addr_ppu", 32'(mem_addr), 32'h00ABCDE);
        wait_ph(10);
        chk("pc_ack_ppu", 32'({ppu_ack, cpu_ack}), 32'b10);
        ppu_req = 0;
        wait_ph(1);
        chk("pc_oe_cpu", 32'({mem_oeB, mem_oeA}), 32'b01);
        chk("pc_addr_cpu", 32'(mem_addr), 32'h0000777);
        wait_ph(10);
        chk("pc_ack_cpu", 32'(cpu_ack), 1);

        // Downloader vs. continuous CPU: loses 4 slots, forced win on the 5th
        dl_req = 1; dl_addr = 25'h1234567; dl_din = 8'h6D;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back(exp_t'{REQ_CPU, 8'h77});
            else       sb.push_back(exp_t'{REQ_DL, 8'h00});
            wait_ph(1);
            chk("dl_we", 32'(mem_we), 32'(i == 4));
            chk("dl_oeA", 32'(mem_oeA), 32'(i < 4));
            chk("dl_wait", 32'(dut.dl_wait), (i < 4) ? i + 1 : 0);
            if (i == 4) begin
                chk("dl_addr", 32'(mem_addr), 32'h1234567);
                chk("dl_din", 32'(mem_din), 32'h6D);
            end
            wait_ph(10);
            if (i == 4) begin
                chk("dl_ack", 32'(dl_ack), 1);
                dl_req = 0; cpu_req = 0;
            end
        end
        wait_ph(1);
        chk("idle_slot", 32'({mem_addr, mem_we, mem_oeA, mem_oeB}), 0);
        wait_ph(11);

        // All requesters continuously: one forced idle slot after 64 grants
        ppu_req = 1; cpu_req = 1; dl_req = 1;
        m_busy = 0; m_dlw = 0; idle_cnt = 0; idle_at = -1;
        for (int s = 0; s < 70; s++) begin
            if (m_busy == 64) begin
                win = REQ_NONE; m_busy = 0;
            end else begin
                win = (m_dlw == 4) ? REQ_DL : REQ_PPU;
                m_busy++;
            end
            m_dlw = (win == REQ_DL) ? 0 : ((m_dlw == 4) ? 4 : m_dlw + 1);
            if (win != REQ_NONE) sb.push_back(exp_t'{win, 8'h3C});
            wait_ph(1);
            chk("rf_oeB", 32'(mem_oeB), 32'(win == REQ_PPU));
            chk("rf_we", 32'(mem_we), 32'(win == REQ_DL));
            if (!mem_oeB && !mem_we && !mem_oeA) begin
                idle_cnt++;
                idle_at = s;
                chk("rf_idle_addr", 32'(mem_addr), 0);
            end
            wait_ph(11);
        end
        ppu_req = 0; cpu_req = 0; dl_req = 0;
        chk("rf_idle_count", idle_cnt, 1);
        chk("rf_idle_slot", idle_at, 64);

        // Reset in the middle of a CPU write: access abandoned, then served fresh
        cpu_req = 1; cpu_we = 1; cpu_addr = 25'h0000AAA; cpu_din = 8'h11;
        wait_ph(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_mem", 32'({mem_addr, mem_we, mem_din}), 0);
        chk("mr_dout", 32'(cpu_dout), 0);
        wait_ph(11);
        sb.push_back(exp_t'{REQ_CPU, 8'h00});
        wait_ph(1);
        chk("mr_retry_we", 32'(mem_we), 1);
        chk("mr_retry_din", 32'(mem_din), 32'h11);
        wait_ph(10);
        chk("mr_retry_ack", 32'(cpu_ack), 1);
        cpu_req = 0; cpu_we = 0;

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
